peas_scheduler: RTL and testbench

Owns the table of on-screen peas and shares the single pea renderer between them. Spawns peas on request, scrolls them left once per frame, retires them when they leave the screen or are eaten, and for every pixel presents the renderer with the position and type of the one pea covering that pixel. It sits between the game-logic spawner/collision logic and the pea renderer, whose `peas_valid/peas_x/peas_y/peas_type` inputs it drives.

---
 rtl/peas_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_peas_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peas_scheduler.sv
// Pea slot table: spawns peas into free slots, scrolls them left once per frame,
// retires or eats them, and picks the lowest-index pea covering the current pixel.
module peas_scheduler #(
   parameter int          NUM_PEAS = 4,
   parameter logic [9:0]  SPAWN_X  = 10'd624,
   parameter logic [9:0]  STEP     = 10'd2,
   parameter logic [9:0]  PEA_W    = 10'd16,
   parameter logic [9:0]  PEA_H    = 10'd15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                frame_tick,
   input  logic                spawn_req,
   input  logic [9:0]          spawn_y,
   input  logic [2:0]          spawn_type,
   output logic                spawn_ack,
   input  logic                eat_valid,
   input  logic [1:0]          eat_slot,
   input  logic [9:0]          current_pixel_x,
   input  logic [9:0]          current_pixel_y,
   output logic                peas_valid,
   output logic [9:0]          peas_x,
   output logic [9:0]          peas_y,
   output logic [2:0]          peas_type,
   output logic [NUM_PEAS-1:0] active_mask,
   output logic                busy,
   output logic [7:0]          eaten_cnt
);

   typedef enum logic {ST_IDLE = 1'b0, ST_UPDATE = 1'b1} state_e;

   state_e              state_q, state_d;
   logic [1:0]          idx_q, idx_d;
   logic [NUM_PEAS-1:0] act_q, act_d;
   logic [9:0]          x_q [NUM_PEAS];
   logic [9:0]          x_d [NUM_PEAS];
   logic [9:0]          y_q [NUM_PEAS];
   logic [9:0]          y_d [NUM_PEAS];
   logic [2:0]          type_q [NUM_PEAS];
   logic [2:0]          type_d [NUM_PEAS];
   logic                spawn_ack_q, spawn_ack_d;
   logic [7:0]          eaten_cnt_q, eaten_cnt_d;

   logic                free_found_s;
   logic [1:0]          free_slot_s;
   logic [10:0]         x_end_s [NUM_PEAS];
   logic [10:0]         y_end_s [NUM_PEAS];
   logic [NUM_PEAS-1:0] hit_s;
   logic                sel_found_s;
   logic [1:0]          sel_s;

   // Lowest-index free slot, taken from the registered table so a slot freed
   // by an eat this cycle only becomes eligible on the next one.
   always_comb begin
      free_found_s = ~(&act_q);
      casez (act_q)
         4'b???0: free_slot_s = 2'd0;
         4'b??01: free_slot_s = 2'd1;
         4'b?011: free_slot_s = 2'd2;
         4'b0111: free_slot_s = 2'd3;
         default: free_slot_s = 2'd0;
      endcase
   end

   // Next-state: frame sweep, spawn, eat and the saturating eaten counter.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      act_d       = act_q;
      x_d         = x_q;
      y_d         = y_q;
      type_d      = type_q;
      spawn_ack_d = 1'b0;
      eaten_cnt_d = eaten_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (frame_tick) begin
               state_d = ST_UPDATE;
               idx_d   = 2'd0;
            end else begin
               state_d = ST_IDLE;
            end
            if (spawn_req && !spawn_ack_q && free_found_s) begin
               act_d[free_slot_s]  = 1'b1;
               x_d[free_slot_s]    = SPAWN_X;
               y_d[free_slot_s]    = spawn_y;
               type_d[free_slot_s] = spawn_type;
               spawn_ack_d         = 1'b1;
            end else begin
               spawn_ack_d = 1'b0;
            end
         end
         ST_UPDATE: begin
            if (act_q[idx_q]) begin
               if (x_q[idx_q] < STEP) begin
                  act_d[idx_q] = 1'b0;
               end else begin
                  x_d[idx_q] = x_q[idx_q] - STEP;
               end
            end else begin
               act_d[idx_q] = 1'b0;
            end
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_UPDATE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
         end
      endcase

      // Eat overrides the sweep: the slot is cleared and keeps its old x.
      if (eat_valid && act_q[eat_slot]) begin
         act_d[eat_slot] = 1'b0;
         x_d[eat_slot]   = x_q[eat_slot];
         if (eaten_cnt_q != 8'd255) begin
            eaten_cnt_d = eaten_cnt_q + 8'd1;
         end else begin
            eaten_cnt_d = eaten_cnt_q;
         end
      end else begin
         eaten_cnt_d = eaten_cnt_q;
      end
   end

   // Per-slot hit test; bounds are widened to 11 bits so x+15 cannot wrap.
   always_comb begin
      for (int i = 0; i < NUM_PEAS; i++) begin
         x_end_s[i] = {1'b0, x_q[i]} + {1'b0, PEA_W} - 11'd1;
         y_end_s[i] = {1'b0, y_q[i]} + {1'b0, PEA_H} - 11'd1;
         hit_s[i]   = act_q[i]
                      && ({1'b0, current_pixel_x} >= {1'b0, x_q[i]})
                      && ({1'b0, current_pixel_x} <= x_end_s[i])
                      && ({1'b0, current_pixel_y} >= {1'b0, y_q[i]})
                      && ({1'b0, current_pixel_y} <= y_end_s[i]);
      end
   end

   // Lowest-index hit wins the renderer.
   always_comb begin
      sel_found_s = |hit_s;
      casez (hit_s)
         4'b???1: sel_s = 2'd0;
         4'b??10: sel_s = 2'd1;
         4'b?100: sel_s = 2'd2;
         4'b1000: sel_s = 2'd3;
         default: sel_s = 2'd0;
      endcase
   end

   assign peas_valid  = sel_found_s;
   assign peas_x      = sel_found_s ? x_q[sel_s]    : 10'd0;
   assign peas_y      = sel_found_s ? y_q[sel_s]    : 10'd0;
   assign peas_type   = sel_found_s ? type_q[sel_s] : 3'd0;
   assign active_mask = act_q;
   assign busy        = (state_q == ST_UPDATE);
   assign spawn_ack   = spawn_ack_q;
   assign eaten_cnt   = eaten_cnt_q;

   // State, slot table and registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= 2'd0;
         act_q       <= '0;
         spawn_ack_q <= 1'b0;
         eaten_cnt_q <= 8'd0;
         for (int i = 0; i < NUM_PEAS; i++) begin
            x_q[i]    <= 10'd0;
            y_q[i]    <= 10'd0;
            type_q[i] <= 3'd0;
         end
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         act_q       <= act_d;
         spawn_ack_q <= spawn_ack_d;
         eaten_cnt_q <= eaten_cnt_d;
         x_q         <= x_d;
         y_q         <= y_d;
         type_q      <= type_d;
      end
   end

endmodule

// File: tb/tb_peas_scheduler.sv
// Directed bench for peas_scheduler: spawn, scroll/retire, overlap select,
// eat rules, counter saturation and reset during a sweep.
module tb_peas_scheduler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_tick;
   logic       spawn_req;
   logic [9:0] spawn_y;
   logic [2:0] spawn_type;
   logic       spawn_ack;
   logic       eat_valid;
   logic [1:0] eat_slot;
   logic [9:0] px;
   logic [9:0] py;
   logic       peas_valid;
   logic [9:0] peas_x;
   logic [9:0] peas_y;
   logic [2:0] peas_type;
   logic [3:0] active_mask;
   logic       busy;
   logic [7:0] eaten_cnt;

   int errors = 0;
   int checks = 0;

   peas_scheduler dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .frame_tick      (frame_tick),
      .spawn_req       (spawn_req),
      .spawn_y         (spawn_y),
      .spawn_type      (spawn_type),
      .spawn_ack       (spawn_ack),
      .eat_valid       (eat_valid),
      .eat_slot        (eat_slot),
      .current_pixel_x (px),
      .current_pixel_y (py),
      .peas_valid      (peas_valid),
      .peas_x          (peas_x),
      .peas_y          (peas_y),
      .peas_type       (peas_type),
      .active_mask     (active_mask),
      .busy            (busy),
      .eaten_cnt       (eaten_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pix(input logic [9:0] x, input logic [9:0] y);
      px = x;
      py = y;
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic frame();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      repeat (4) step();
   endtask

   task automatic spawn_one(input logic [9:0] y, input logic [2:0] t);
      logic got;
      got        = 1'b0;
      spawn_y    = y;
      spawn_type = t;
      spawn_req  = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         if (spawn_ack) begin
            got = 1'b1;
            break;
         end
      end
      spawn_req = 1'b0;
      chk("spawn_one_ack", 32'(got), 32'd1);
   endtask

   task automatic eat(input logic [1:0] s);
      eat_valid = 1'b1;
      eat_slot  = s;
      step();
      eat_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; frame_tick = 1'b0; spawn_req = 1'b0; spawn_y = 10'd0;
      spawn_type = 3'd0; eat_valid = 1'b0; eat_slot = 2'd0; px = 10'd0; py = 10'd0;
      step();
      step();
      chk("rst_mask", 32'(active_mask), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(peas_valid), 32'd0);
      chk("rst_cnt", 32'(eaten_cnt), 32'd0);
      chk("rst_ack", 32'(spawn_ack), 32'd0);
      rst_n = 1'b1;

      // Single spawn and pixel select edges.
      spawn_y = 10'd100; spawn_type = 3'd3; spawn_req = 1'b1;
      step();
      chk("sp1_ack", 32'(spawn_ack), 32'd1);
      chk("sp1_mask", 32'(active_mask), 32'd1);
      spawn_req = 1'b0;
      pix(10'd630, 10'd110);
      chk("sp1_valid", 32'(peas_valid), 32'd1);
      chk("sp1_x", 32'(peas_x), 32'd624);
      chk("sp1_y", 32'(peas_y), 32'd100);
      chk("sp1_type", 32'(peas_type), 32'd3);
      pix(10'd640, 10'd110);
      chk("sp1_miss_valid", 32'(peas_valid), 32'd0);
      chk("sp1_miss_x", 32'(peas_x), 32'd0);

      // Held request: acks every other cycle until the table is full.
      do_reset();
      spawn_y = 10'd20; spawn_type = 3'd1; spawn_req = 1'b1;
      step();
      chk("bb_ack0", 32'(spawn_ack), 32'd1);
      chk("bb_mask0", 32'(active_mask), 32'd1);
      spawn_y = 10'd60; spawn_type = 3'd2;
      step();
      chk("bb_noreaccept", 32'(spawn_ack), 32'd0);
      step();
      chk("bb_ack1", 32'(spawn_ack), 32'd1);
      chk("bb_mask1", 32'(active_mask), 32'd3);
      spawn_y = 10'd100; spawn_type = 3'd3;
      step();
      step();
      chk("bb_mask2", 32'(active_mask), 32'd7);
      spawn_y = 10'd140; spawn_type = 3'd4;
      step();
      step();
      chk("bb_ack3", 32'(spawn_ack), 32'd1);
      chk("bb_mask3", 32'(active_mask), 32'd15);
      spawn_y = 10'd300; spawn_type = 3'd5;
      step();
      step();
      chk("bb_full_noack", 32'(spawn_ack), 32'd0);
      eat_valid = 1'b1; eat_slot = 2'd2;
      step();
      eat_valid = 1'b0;
      chk("bb_eat_mask", 32'(active_mask), 32'd11);
      chk("bb_eat_cnt", 32'(eaten_cnt), 32'd1);
      chk("bb_eat_noack", 32'(spawn_ack), 32'd0);
      step();
      chk("bb_ack4", 32'(spawn_ack), 32'd1);
      chk("bb_mask4", 32'(active_mask), 32'd15);
      spawn_req = 1'b0;
      pix(10'd630, 10'd305);
      chk("bb_slot2_y", 32'(peas_y), 32'd300);
      chk("bb_slot2_type", 32'(peas_type), 32'd5);

      // Sweep timing, ignored frame_tick in UPDATE, and retirement boundary.
      do_reset();
      spawn_one(10'd200, 3'd2);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("upd_busy0", 32'(busy), 32'd1);
      step();
      chk("upd_busy1", 32'(busy), 32'd1);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      chk("upd_busy2", 32'(busy), 32'd1);
      step();
      chk("upd_busy3", 32'(busy), 32'd1);
      step();
      chk("upd_done", 32'(busy), 32'd0);
      step();
      chk("upd_tick_ignored", 32'(busy), 32'd0);
      pix(10'd622, 10'd200);
      chk("upd_x622", 32'(peas_x), 32'd622);
      for (int f = 0; f < 310; f++) frame();
      pix(10'd2, 10'd200);
      chk("ret_x2_valid", 32'(peas_valid), 32'd1);
      chk("ret_x2", 32'(peas_x), 32'd2);
      frame();
      pix(10'd0, 10'd200);
      chk("ret_x0_mask", 32'(active_mask), 32'd1);
      chk("ret_x0", 32'(peas_x), 32'd0);
      chk("ret_x0_valid", 32'(peas_valid), 32'd1);
      frame();
      chk("ret_gone_mask", 32'(active_mask), 32'd0);
      chk("ret_gone_valid", 32'(peas_valid), 32'd0);

      // Overlap: slot0 at (200,50), slot1 at (206,55).
      do_reset();
      spawn_one(10'd50, 3'd1);
      repeat (3) frame();
      spawn_one(10'd55, 3'd6);
      for (int f = 0; f < 209; f++) frame();
      pix(10'd210, 10'd60);
      chk("ovl_x", 32'(peas_x), 32'd200);
      chk("ovl_y", 32'(peas_y), 32'd50);
      chk("ovl_type", 32'(peas_type), 32'd1);
      pix(10'd218, 10'd60);
      chk("ovl_right_x", 32'(peas_x), 32'd206);
      chk("ovl_right_type", 32'(peas_type), 32'd6);
      pix(10'd210, 10'd65);
      chk("ovl_below_y", 32'(peas_y), 32'd55);
      pix(10'd210, 10'd64);
      chk("ovl_lastrow_y", 32'(peas_y), 32'd50);
      pix(10'd199, 10'd50);
      chk("ovl_none_valid", 32'(peas_valid), 32'd0);

      // Eat on the slot the sweep is processing this cycle.
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      eat_valid = 1'b1; eat_slot = 2'd1;
      step();
      eat_valid = 1'b0;
      chk("eatupd_mask", 32'(active_mask), 32'd1);
      chk("eatupd_cnt", 32'(eaten_cnt), 32'd1);
      chk("eatupd_busy", 32'(busy), 32'd1);
      step();
      step();
      chk("eatupd_done", 32'(busy), 32'd0);
      pix(10'd198, 10'd50);
      chk("eatupd_x0", 32'(peas_x), 32'd198);
      eat(2'd1);
      chk("eat_inactive1", 32'(eaten_cnt), 32'd1);
      eat(2'd3);
      chk("eat_inactive3", 32'(eaten_cnt), 32'd1);

      // Counter saturation: respawn into slot1 and eat it, 300 times.
      for (int i = 0; i < 300; i++) begin
         spawn_one(10'd400, 3'd2);
         eat(2'd1);
         if (i == 252) chk("cnt_254", 32'(eaten_cnt), 32'd254);
      end
      chk("cnt_sat", 32'(eaten_cnt), 32'd255);
      chk("cnt_mask", 32'(active_mask), 32'd1);

      // Reset while the sweep is on slot 2.
      spawn_one(10'd120, 3'd4);
      chk("rstupd_mask_pre", 32'(active_mask), 32'd3);
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
      step();
      pix(10'd198, 10'd50);
      rst_n = 1'b0;
      #1;
      chk("rstupd_mask", 32'(active_mask), 32'd0);
      chk("rstupd_busy", 32'(busy), 32'd0);
      chk("rstupd_cnt", 32'(eaten_cnt), 32'd0);
      chk("rstupd_valid", 32'(peas_valid), 32'd0);
      chk("rstupd_ack", 32'(spawn_ack), 32'd0);
      step();
      rst_n = 1'b1;
      spawn_y = 10'd77; spawn_type = 3'd7; spawn_req = 1'b1;
      step();
      spawn_req = 1'b0;
      chk("rstupd_sp_ack", 32'(spawn_ack), 32'd1);
      chk("rstupd_sp_mask", 32'(active_mask), 32'd1);
      chk("rstupd_sp_busy", 32'(busy), 32'd0);
      pix(10'd624, 10'd80);
      chk("rstupd_sp_type", 32'(peas_type), 32'd7);
      chk("rstupd_sp_y", 32'(peas_y), 32'd77);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
